// File: rtl/pwm_loop_pkg.sv
// Shared definitions for the PWM generate/capture loop: default widths and
// the capture FSM state encoding.
package pwm_loop_pkg;

    localparam int PWM_BIT_WIDTH   = 8;
    localparam int PWM_SYNC_STAGES = 2;

    typedef logic [0:0] cap_state_t;

    localparam cap_state_t CAP_IDLE    = 1'b0;
    localparam cap_state_t CAP_MEASURE = 1'b1;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus a registered
// one-cycle rising-edge detector on the synchronized value.
module pwm_sync_edge #(
    parameter int sync_stages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic s,
    output logic rise
);

    logic [sync_stages-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], raw};
            s_d    <= sync_q[sync_stages-1];
        end
    end

    assign s    = sync_q[sync_stages-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM waveform between successive rising
// edges, with saturating counters and a one-cycle valid per period.
module pwm_capture
    import pwm_loop_pkg::*;
#(
    parameter int bit_width   = PWM_BIT_WIDTH,
    parameter int sync_stages = PWM_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               pwm_in,
    output logic [bit_width:0] period_count,
    output logic [bit_width:0] high_count,
    output logic               valid,
    output logic               overflow,
    output logic               timeout,
    output logic               level,
    output cap_state_t         fsm_state
);

    localparam int CW = bit_width + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic          s;
    logic          rise;
    cap_state_t    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hi;
    logic          ovf;

    pwm_sync_edge #(.sync_stages(sync_stages)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .raw  (pwm_in),
        .s    (s),
        .rise (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CAP_IDLE;
            cnt          <= '0;
            hi           <= '0;
            ovf          <= 1'b0;
            period_count <= '0;
            high_count   <= '0;
            overflow     <= 1'b0;
            valid        <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                // Published counts are deliberately left holding.
                state <= CAP_IDLE;
                cnt   <= '0;
                hi    <= '0;
                ovf   <= 1'b0;
            end else if (state == CAP_IDLE) begin
                if (rise) begin
                    state <= CAP_MEASURE;
                    cnt   <= CNT_ONE;
                    hi    <= CNT_ONE;
                    ovf   <= 1'b0;
                end
            end else if (rise) begin
                period_count <= cnt;
                high_count   <= hi;
                overflow     <= ovf;
                valid        <= 1'b1;
                cnt          <= CNT_ONE;
                hi           <= CNT_ONE;
                ovf          <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                if (s && (hi != CNT_MAX)) hi <= hi + CNT_ONE;
                // Overflow means an increment was actually lost, not merely reaching max.
                if ((cnt == CNT_MAX) || (s && (hi == CNT_MAX))) ovf <= 1'b1;
            end
        end
    end

    assign timeout   = enable && (state == CAP_MEASURE) && (cnt == CNT_MAX);
    assign level     = s;
    assign fsm_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed-plus-random bench for pwm_capture against a time-stamp based
// reference model of the period/high-time measurement.
module tb_pwm_capture;
    import pwm_loop_pkg::*;

    localparam int BW      = 8;
    localparam int SAT     = (1 << (BW + 1)) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          pwm_in;
    logic [BW:0]   period_count;
    logic [BW:0]   high_count;
    logic          valid;
    logic          overflow;
    logic          timeout;
    logic          level;
    cap_state_t    fsm_state;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Reference model state: input seen through a 2-edge delay, rises time-stamped.
    logic d1, d2, u_prev;
    logic armed;
    int   last_rise;
    int   hcount;
    int   m_period, m_high;
    logic m_ovf, m_valid, m_timeout, m_level;

    pwm_capture #(.bit_width(BW), .sync_stages(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .period_count (period_count),
        .high_count   (high_count),
        .valid        (valid),
        .overflow     (overflow),
        .timeout      (timeout),
        .level        (level),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_step(input logic v);
        logic u;
        logic r;
        int   elapsed;
        if (rst) begin
            d1 = 1'b0; d2 = 1'b0; u_prev = 1'b0; armed = 1'b0;
            last_rise = 0; hcount = 0;
            m_period = 0; m_high = 0; m_ovf = 1'b0;
            m_valid = 1'b0; m_timeout = 1'b0; m_level = 1'b0;
            return;
        end
        u  = d2;
        d2 = d1;
        d1 = v;
        m_level = d2;
        r = u & ~u_prev;
        u_prev = u;
        m_valid = 1'b0;
        if (!enable) begin
            armed = 1'b0;
        end else if (r) begin
            if (armed) begin
                elapsed  = edge_n - last_rise;
                m_period = (elapsed > SAT) ? SAT : elapsed;
                m_high   = (hcount > SAT) ? SAT : hcount;
                m_ovf    = (elapsed > SAT);
                m_valid  = 1'b1;
            end
            armed     = 1'b1;
            last_rise = edge_n;
            hcount    = 1;
        end else if (armed) begin
            hcount += int'(u);
        end
        m_timeout = armed && ((edge_n - last_rise) >= SAT - 1);
    endtask

    task automatic tick(input logic v);
        pwm_in = v;
        @(posedge clk);
        edge_n++;
        model_step(v);
        @(negedge clk);
        check("valid",        32'(valid),        32'(m_valid));
        check("period_count", 32'(period_count), m_period);
        check("high_count",   32'(high_count),   m_high);
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("timeout",      32'(timeout),      32'(m_timeout));
        check("level",        32'(level),        32'(m_level));
    endtask

    task automatic run_wave(input int p, input int h, input int nper);
        for (int k = 0; k < nper; k++)
            for (int i = 0; i < p; i++)
                tick(i < h);
    endtask

    initial begin
        int p, h;
        rst = 1'b1; enable = 1'b1; pwm_in = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0);

        // Period 256 / high 100, as produced by an 8-bit generator
        run_wave(256, 100, 4);

        // Short period with a duty change mid-stream
        run_wave(10, 3, 5);
        run_wave(10, 7, 3);

        // Random waveforms inside the measurable range, including period 2
        run_wave(2, 1, 3);
        for (int k = 0; k < 8; k++) begin
            p = $urandom_range(60, 2);
            h = $urandom_range(p - 1, 1);
            run_wave(p, h, 3);
        end

        // Stuck low after one rise, then stuck high
        tick(1'b1);
        for (int i = 0; i < 600; i++) tick(1'b0);
        for (int i = 0; i < 600; i++) tick(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0);

        // Period beyond the counter range, then back to normal
        run_wave(600, 550, 3);
        run_wave(20, 5, 3);
        run_wave(511, 200, 3);

        // Reset halfway through a period
        run_wave(30, 10, 2);
        for (int i = 0; i < 15; i++) tick(i < 10);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        for (int i = 16; i < 30; i++) tick(1'b0);
        run_wave(30, 10, 3);

        // Enable dropped halfway through a period
        run_wave(40, 10, 2);
        for (int i = 0; i < 20; i++) tick(i < 10);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        enable = 1'b1;
        for (int i = 23; i < 40; i++) tick(1'b0);
        run_wave(40, 10, 3);

        // Random tail
        for (int k = 0; k < 4; k++) begin
            p = $urandom_range(40, 3);
            h = $urandom_range(p - 1, 1);
            run_wave(p, h, 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
